dac_wave_generator: RTL and testbench
=====================================

// Module: dac_wave_generator
// PURPOSE
//   Sample source for the PMOD R-2R DAC stage. Replaces the constant DAC byte with a live 8-bit waveform.
//   Produces saw, triangle, square or constant mid-scale output at a fixed sample rate derived from i_Clk.
//   The debounced board switch steps through the modes. o_Byte drives the DAC stage's i_byte directly.
// PARAMETERS
//   CLKS_PER_SAMPLE  250  i_Clk cycles per output sample (>=2); 250 @ 25 MHz = 100 kHz sample rate
// PORTS
//   i_Clk           in   1  system clock; single clock domain
//   i_Reset         in   1  synchronous, active-high reset
//   i_Enable        in   1  1 = generate samples; 0 = freeze output and prescaler
//   i_Mode_Next     in   1  debounced switch level; each rising edge advances the mode
//   i_Step          in   8  phase/amplitude increment per sample (unsigned)
//   o_Byte          out  8  current DAC sample, registered
//   o_Sample_Valid  out  1  one-cycle pulse on the cycle o_Byte takes a new sample
//   o_Mode          out  2  0=SAW 1=TRIANGLE 2=SQUARE 3=MID (constant 8'h80)
// BEHAVIOUR
//   Reset (sync, i_Reset=1 at edge):
//     - prescaler=0, phase=0, tri=0, tri_dir=UP, o_Mode=0, o_Byte=8'h00, o_Sample_Valid=0.
//     - Switch-edge register loads i_Mode_Next. A switch held high through reset release causes no mode step.
//   Prescaler: counts 0..CLKS_PER_SAMPLE-1 while i_Enable=1, then wraps. tick = (count==CLKS_PER_SAMPLE-1) & i_Enable.
//   i_Enable=0: prescaler cleared to 0 and held. No ticks. o_Byte, phase and tri hold. Mode edges still honoured.
//   On the tick edge (no mode edge), these update together and o_Sample_Valid=1 for exactly that cycle:
//     - phase_n = phase + i_Step, mod 256; phase <= phase_n.
//     - o_Byte is set by mode:
//       - SAW: o_Byte <= phase_n.
//       - SQUARE: o_Byte <= phase_n[7] ? 8'hFF : 8'h00.
//       - MID: o_Byte <= 8'h80.
//       - TRIANGLE: 2-state FSM {UP, DOWN} on register tri, 9-bit intermediate arithmetic:
//         - UP: if tri + i_Step >= 255 then tri <= 8'hFF, dir <= DOWN; else tri <= tri + i_Step.
//         - DOWN: if tri <= i_Step then tri <= 8'h00, dir <= UP; else tri <= tri - i_Step.
//         - o_Byte <= new tri value.
//       - The FSM only advances on ticks in TRIANGLE mode.
//   Latency: o_Byte and o_Sample_Valid change at the same edge as the tick, i.e. 1 cycle after count reaches N-1.
//   i_Step = 0: samples still emitted each tick with an unchanged value; the triangle stays in its current direction.
//   Mode edge (i_Mode_Next 0->1 vs previous cycle):
//     - o_Mode <= o_Mode + 1, with 3 wrapping to 0. phase <= 0, tri <= 0, dir <= UP.
//     - Prescaler is not disturbed. o_Byte holds its old value until the next tick.
//   Simultaneous mode edge and tick: the mode edge wins. o_Sample_Valid=0 that cycle and the tick is dropped.
//     The next sample is computed from phase=0 in the new mode.
//   Reset mid-operation overrides everything: all state returns to reset values on the next edge.
// TESTING (CLKS_PER_SAMPLE=4 for the bench)
//   1 Hold reset 3 cycles with i_Mode_Next=1, then release -> o_Byte=00, o_Mode=0, valid=0, no mode step after release.
//   2 SAW, i_Step=10, i_Enable=1 -> valid every 4th cycle; o_Byte 10,20,...,F0,00,10 (wraps).
//   3 TRIANGLE, i_Step=60 -> o_Byte 60,C0,FF,9F,3F,00,60 (saturates at FF and at 00, direction reverses).
//   4 SQUARE, i_Step=40 -> o_Byte 00,FF,FF,00,00,FF (phase 40,80,C0,00,40,80).
//   5 Mode edge on the same cycle as a tick, SAW -> TRIANGLE -> valid stays 0, o_Mode=1, old o_Byte held.
//     Next tick gives o_Byte=i_Step.
//   6 i_Enable=0 for 10 cycles mid-run -> no valid pulses, o_Byte constant, prescaler restarts at 0.
//     Then i_Reset for 1 cycle -> o_Byte=00, o_Mode=0.

Source files
------------

// File: rtl/dac_wave_generator.sv
// dac_wave_generator: 8-bit waveform sample source (saw / triangle / square / mid-scale)
// feeding the PMOD R-2R DAC stage at a fixed sample rate derived from i_Clk.
module dac_wave_generator #(
   parameter int CLKS_PER_SAMPLE = 250
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Enable,
   input  logic       i_Mode_Next,
   input  logic [7:0] i_Step,
   output logic [7:0] o_Byte,
   output logic       o_Sample_Valid,
   output logic [1:0] o_Mode
);

   localparam int CW = (CLKS_PER_SAMPLE > 2) ? $clog2(CLKS_PER_SAMPLE) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_SAMPLE - 1);

   localparam logic [1:0] MODE_SAW    = 2'd0;
   localparam logic [1:0] MODE_TRI    = 2'd1;
   localparam logic [1:0] MODE_SQUARE = 2'd2;

   typedef enum logic {TRI_UP = 1'b0, TRI_DOWN = 1'b1} tri_dir_t;

   logic [CW-1:0] prescale_count;
   logic [7:0]    phase;
   logic [7:0]    tri_val;
   tri_dir_t      tri_dir;
   logic          mode_next_prev;

   logic          tick;
   logic          mode_edge;
   logic [7:0]    phase_n;
   logic [8:0]    tri_sum;
   logic [7:0]    tri_n;
   tri_dir_t      tri_dir_n;

   assign tick      = (prescale_count == LAST_COUNT) && i_Enable;
   assign mode_edge = i_Mode_Next && !mode_next_prev;
   assign phase_n   = phase + i_Step;
   assign tri_sum   = {1'b0, tri_val} + {1'b0, i_Step};

   // Next triangle value and direction, saturating at both rails before reversing.
   always_comb begin
      tri_n     = tri_val;
      tri_dir_n = tri_dir;
      if (tri_dir == TRI_UP) begin
         if (tri_sum >= 9'd255) begin
            tri_n     = 8'hFF;
            tri_dir_n = TRI_DOWN;
         end else begin
            tri_n = tri_sum[7:0];
         end
      end else begin
         if (tri_val <= i_Step) begin
            tri_n     = 8'h00;
            tri_dir_n = TRI_UP;
         end else begin
            tri_n = tri_val - i_Step;
         end
      end
   end

   // Prescaler, mode stepping and sample generation; a mode edge takes priority over a tick.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         prescale_count <= '0;
         phase          <= 8'h00;
         tri_val        <= 8'h00;
         tri_dir        <= TRI_UP;
         o_Mode         <= 2'd0;
         o_Byte         <= 8'h00;
         o_Sample_Valid <= 1'b0;
         mode_next_prev <= i_Mode_Next;
      end else begin
         mode_next_prev <= i_Mode_Next;
         o_Sample_Valid <= 1'b0;

         if (!i_Enable || prescale_count == LAST_COUNT) begin
            prescale_count <= '0;
         end else begin
            prescale_count <= prescale_count + 1'b1;
         end

         if (mode_edge) begin
            o_Mode  <= o_Mode + 2'd1;
            phase   <= 8'h00;
            tri_val <= 8'h00;
            tri_dir <= TRI_UP;
         end else if (tick) begin
            phase          <= phase_n;
            o_Sample_Valid <= 1'b1;
            case (o_Mode)
               MODE_SAW:    o_Byte <= phase_n;
               MODE_TRI: begin
                  tri_val <= tri_n;
                  tri_dir <= tri_dir_n;
                  o_Byte  <= tri_n;
               end
               MODE_SQUARE: o_Byte <= phase_n[7] ? 8'hFF : 8'h00;
               default:     o_Byte <= 8'h80;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dac_wave_generator.sv
// tb_dac_wave_generator: directed waveform sequences plus randomized traffic
// checked every cycle against a behavioural model of the sample generator.
module tb_dac_wave_generator;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       mode_next;
   logic [7:0] step;
   logic [7:0] dac_byte;
   logic       sample_valid;
   logic [1:0] mode;

   int total = 0;
   int bad   = 0;

   // Behavioural model state (plain integers)
   int m_count, m_phase, m_tri, m_mode, m_byte;
   bit m_up, m_valid, m_prev;

   dac_wave_generator #(.CLKS_PER_SAMPLE(N)) dut (
      .i_Clk          (clk),
      .i_Reset        (reset),
      .i_Enable       (enable),
      .i_Mode_Next    (mode_next),
      .i_Step         (step),
      .o_Byte         (dac_byte),
      .o_Sample_Valid (sample_valid),
      .o_Mode         (mode)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelEdge(input bit rst, input bit en, input bit mn, input int stp);
      bit edge_seen, tick;
      if (rst) begin
         m_count = 0; m_phase = 0; m_tri = 0; m_up = 1;
         m_mode = 0; m_byte = 0; m_valid = 0; m_prev = mn;
         return;
      end
      edge_seen = mn && !m_prev;
      m_prev    = mn;
      tick      = en && (m_count == N - 1);
      m_count   = en ? (m_count + 1) % N : 0;
      m_valid   = 0;
      if (edge_seen) begin
         m_mode = (m_mode + 1) % 4;
         m_phase = 0; m_tri = 0; m_up = 1;
      end else if (tick) begin
         m_phase = (m_phase + stp) % 256;
         m_valid = 1;
         case (m_mode)
            0: m_byte = m_phase;
            1: begin
               if (m_up) begin
                  if (m_tri + stp >= 255) begin m_tri = 255; m_up = 0; end
                  else m_tri = m_tri + stp;
               end else begin
                  if (m_tri <= stp) begin m_tri = 0; m_up = 1; end
                  else m_tri = m_tri - stp;
               end
               m_byte = m_tri;
            end
            2: m_byte = (m_phase >= 128) ? 255 : 0;
            default: m_byte = 128;
         endcase
      end
   endtask

   // Drive one cycle of inputs, clock it, and compare outputs with the model.
   task automatic applyStimulus(input bit rst, input bit en, input bit mn, input logic [7:0] stp);
      reset = rst; enable = en; mode_next = mn; step = stp;
      @(posedge clk);
      modelEdge(rst, en, mn, int'(stp));
      #1;
      checkOutput("byte",  int'(dac_byte), m_byte);
      checkOutput("valid", int'(sample_valid), int'(m_valid));
      checkOutput("mode",  int'(mode), m_mode);
   endtask

   // Run until the next sample pulse (bounded) and check it against a fixed value.
   task automatic waitSample(input string tag, input logic [7:0] stp, input int exp);
      bit got;
      got = 0;
      for (int c = 0; c < 2 * N + 2 && !got; c++) begin
         applyStimulus(0, 1, 0, stp);
         if (sample_valid) got = 1;
      end
      if (!got) checkOutput({tag, "_timeout"}, 0, 1);
      else      checkOutput(tag, int'(dac_byte), exp);
   endtask

   // Single-cycle pulse on the mode switch
   task automatic pulseMode(input logic [7:0] stp);
      applyStimulus(0, 1, 1, stp);
      applyStimulus(0, 1, 0, stp);
   endtask

   int saw_exp[17];
   int tri_exp[7] = '{8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F, 8'h00, 8'h60};
   int sq_exp[6]  = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};

   initial begin
      int held_byte, gap;
      bit r, e, mnl;
      for (int i = 0; i < 17; i++) saw_exp[i] = ((i + 1) * 16) % 256;

      // Reset held with switch high, then released while still high
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 8'h00);
      checkOutput("reset_byte", int'(dac_byte), 0);
      checkOutput("reset_mode", int'(mode), 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h00);
      checkOutput("no_step_after_reset", int'(mode), 0);
      applyStimulus(0, 0, 0, 8'h00);

      // Saw wrap
      for (int i = 0; i < 17; i++) waitSample("saw", 8'h10, saw_exp[i]);

      // Triangle saturating at both rails
      pulseMode(8'h60);
      checkOutput("mode_tri", int'(mode), 1);
      for (int i = 0; i < 7; i++) waitSample("tri", 8'h60, tri_exp[i]);

      // Square
      pulseMode(8'h40);
      checkOutput("mode_sq", int'(mode), 2);
      for (int i = 0; i < 6; i++) waitSample("square", 8'h40, sq_exp[i]);

      // Back to SAW via MID, then a mode edge exactly on a tick
      pulseMode(8'h40);
      waitSample("mid", 8'h40, 8'h80);
      pulseMode(8'h40);
      checkOutput("mode_wrap", int'(mode), 0);
      waitSample("saw2", 8'h40, 8'h40);
      for (int c = 0; c < 2 * N && m_count != N - 1; c++) applyStimulus(0, 1, 0, 8'h40);
      held_byte = int'(dac_byte);
      applyStimulus(0, 1, 1, 8'h40);
      checkOutput("collide_valid", int'(sample_valid), 0);
      checkOutput("collide_mode", int'(mode), 1);
      checkOutput("collide_byte", int'(dac_byte), held_byte);
      applyStimulus(0, 1, 0, 8'h40);
      waitSample("after_collide", 8'h40, 8'h40);

      // Enable low freezes output; prescaler restarts from zero
      held_byte = int'(dac_byte);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, 8'h40);
         checkOutput("frozen_valid", int'(sample_valid), 0);
         checkOutput("frozen_byte", int'(dac_byte), held_byte);
      end
      gap = 0;
      for (int c = 1; c <= 2 * N && gap == 0; c++) begin
         applyStimulus(0, 1, 0, 8'h40);
         if (sample_valid) gap = c;
      end
      checkOutput("restart_gap", gap, N);
      applyStimulus(1, 1, 0, 8'h40);
      checkOutput("midrun_reset_byte", int'(dac_byte), 0);
      checkOutput("midrun_reset_mode", int'(mode), 0);

      // Randomized traffic against the model
      mnl = 0;
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 59) == 0);
         e = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) == 0) mnl = ~mnl;
         applyStimulus(r, e, mnl, 8'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
